// File: rtl/alu_ex_if.sv
// Handshake bundle between the execute stage, its issue source and the memory/writeback consumer.
// Carries out_ovf only when ALU_EX_OVF_EN is defined.
`timescale 1ns/1ps
interface alu_ex_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_neg;
`ifdef ALU_EX_OVF_EN
    logic             out_ovf;
`endif

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
`ifdef ALU_EX_OVF_EN
        input  out_ovf,
`endif
        input  in_ready, out_valid, out_result, out_zero, out_neg
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
`ifdef ALU_EX_OVF_EN
        output out_ovf,
`endif
        output in_ready, out_valid, out_result, out_zero, out_neg
    );
endinterface

// File: rtl/alu_ex_stage.sv
// Execute stage: one-entry skid buffer in front of a 32-bit ALU, registered result and flags.
// Optional signed-overflow output enabled by macro ALU_EX_OVF_EN.
`timescale 1ns/1ps
module alu_ex_stage #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush,
    alu_ex_if.slave bus
);
    localparam logic [OPW-1:0] OP_AND = 3'b000, OP_OR  = 3'b001, OP_ADD = 3'b010, OP_SUB  = 3'b011,
                               OP_XOR = 3'b100, OP_NOR = 3'b101, OP_SLT = 3'b110, OP_PASS = 3'b111;
    localparam logic signed [WIDTH-1:0] INC1 = 1;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    function automatic logic [WIDTH-1:0] alu_f(input logic [OPW-1:0] op,
                                               input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sum;
        logic signed [WIDTH-1:0] diff;
        logic                    ovf_sub;
        logic [WIDTH-1:0]        res;
        sum     = a + b;
        diff    = a + ~b + INC1;
        ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        res     = '0;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_ADD:  res = sum;
            OP_SUB:  res = diff;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
            OP_PASS: res = b;
        endcase
        return res;
    endfunction

`ifdef ALU_EX_OVF_EN
    function automatic logic ovf_f(input logic [OPW-1:0] op,
                                   input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sum;
        logic signed [WIDTH-1:0] diff;
        sum  = a + b;
        diff = a + ~b + INC1;
        if (op == OP_ADD)
            return (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        if (op == OP_SUB)
            return (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        return 1'b0;
    endfunction
`endif

    state_t                  state_q, state_d;
    logic                    in_ready_q;
    logic                    load_out, load_skid;
    logic                    accept, consume;
    logic [OPW-1:0]          skid_op;
    logic signed [WIDTH-1:0] skid_a, skid_b;
    logic [OPW-1:0]          op_p0;
    logic signed [WIDTH-1:0] a_p0, b_p0;
    logic [WIDTH-1:0]        res_p0;
    logic                    vld_p1;
    logic [WIDTH-1:0]        res_p1;
    logic                    zero_p1, neg_p1;

    assign accept  = bus.in_valid & in_ready_q;
    assign consume = vld_p1 & bus.out_ready;

    // p0: operand select (skid entry drains first) and combinational ALU
    assign op_p0  = (state_q == S_TWO) ? skid_op : bus.in_op;
    assign a_p0   = (state_q == S_TWO) ? skid_a  : bus.in_a;
    assign b_p0   = (state_q == S_TWO) ? skid_b  : bus.in_b;
    assign res_p0 = alu_f(op_p0, a_p0, b_p0);

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        case (state_q)
            S_EMPTY: if (accept) begin
                state_d  = S_ONE;
                load_out = 1'b1;
            end
            S_ONE: begin
                if (accept && consume) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = S_TWO;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: if (consume) begin
                state_d  = S_ONE;
                load_out = 1'b1;
            end
            default: state_d = S_EMPTY;
        endcase
        if (flush) begin
            state_d   = S_EMPTY;
            load_out  = 1'b0;
            load_skid = 1'b0;
        end
    end

    // p1: output register toward memory/writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
            vld_p1     <= 1'b0;
            res_p1     <= '0;
            zero_p1    <= 1'b0;
            neg_p1     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_TWO);
            vld_p1     <= (state_d != S_EMPTY);
            if (load_out) begin
                res_p1  <= res_p0;
                zero_p1 <= (res_p0 == '0);
                neg_p1  <= res_p0[WIDTH-1];
            end
        end
    end

    // Skid payload needs no reset: its occupancy lives in state_q
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_op <= bus.in_op;
            skid_a  <= bus.in_a;
            skid_b  <= bus.in_b;
        end
    end

`ifdef ALU_EX_OVF_EN
    logic ovf_p1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_p1 <= 1'b0;
        else if (load_out)
            ovf_p1 <= ovf_f(op_p0, a_p0, b_p0);
    end
    assign bus.out_ovf = ovf_p1;
`endif

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = vld_p1;
    assign bus.out_result = res_p1;
    assign bus.out_zero   = zero_p1;
    assign bus.out_neg    = neg_p1;
endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: functions, streaming, backpressure, flush and async reset.
`timescale 1ns/1ps
module tb_alu_ex_stage;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   total = 0;
    int   bad   = 0;

    alu_ex_if #(.WIDTH(32), .OPW(3)) bus();

    alu_ex_stage #(.WIDTH(32), .OPW(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        #12;
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_result", bus.out_result, 32'h0);
        chk("rst_zero", {31'b0, bus.out_zero}, 32'd0);
        chk("rst_neg", {31'b0, bus.out_neg}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // single OR
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b001, 32'hF0F0_0000, 32'h0000_0F0F);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        chk("or_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("or_result", bus.out_result, 32'hF0F0_0F0F);
        chk("or_zero", {31'b0, bus.out_zero}, 32'd0);
        chk("or_neg", {31'b0, bus.out_neg}, 32'd1);
        step();
        chk("or_drain", {31'b0, bus.out_valid}, 32'd0);

        // back-to-back stream
        drive(1'b1, 3'b010, 32'd1, 32'd1);
        step();
        chk("s1_result", bus.out_result, 32'd2);
        chk("s1_ready", {31'b0, bus.in_ready}, 32'd1);
        drive(1'b1, 3'b010, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("s2_result", bus.out_result, 32'd0);
        chk("s2_zero", {31'b0, bus.out_zero}, 32'd1);
        chk("s2_ready", {31'b0, bus.in_ready}, 32'd1);
        drive(1'b1, 3'b011, 32'd5, 32'd5);
        step();
        chk("s3_result", bus.out_result, 32'd0);
        chk("s3_zero", {31'b0, bus.out_zero}, 32'd1);
        chk("s3_valid", {31'b0, bus.out_valid}, 32'd1);
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        step();
        chk("s_drain", {31'b0, bus.out_valid}, 32'd0);

        // backpressure into the skid entry
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'hFF, 32'h0F);
        step();
        chk("bp1_result", bus.out_result, 32'h0F);
        chk("bp1_ready", {31'b0, bus.in_ready}, 32'd1);
        drive(1'b1, 3'b100, 32'd3, 32'd1);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        chk("bp2_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("bp2_result", bus.out_result, 32'h0F);
        step();
        chk("bp_hold_result", bus.out_result, 32'h0F);
        chk("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        step();
        chk("bp_second", bus.out_result, 32'h2);
        chk("bp_second_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("bp_ready_back", {31'b0, bus.in_ready}, 32'd1);
        step();
        chk("bp_drain", {31'b0, bus.out_valid}, 32'd0);

        // signed compare, NOR, PASSB
        drive(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("slt_neg_lt", bus.out_result, 32'd1);
        drive(1'b1, 3'b110, 32'd1, 32'hFFFF_FFFF);
        step();
        chk("slt_pos_ge", bus.out_result, 32'd0);
        drive(1'b1, 3'b110, 32'h8000_0000, 32'h7FFF_FFFF);
        step();
        chk("slt_ovf_case", bus.out_result, 32'd1);
        drive(1'b1, 3'b101, 32'h0, 32'h0);
        step();
        chk("nor_result", bus.out_result, 32'hFFFF_FFFF);
`ifdef ALU_EX_OVF_EN
        chk("nor_ovf", {31'b0, bus.out_ovf}, 32'd0);
`endif
        drive(1'b1, 3'b111, 32'h1234_5678, 32'hCAFE_0001);
        step();
        chk("passb_result", bus.out_result, 32'hCAFE_0001);
        drive(1'b1, 3'b010, 32'h7FFF_FFFF, 32'd1);
        step();
        chk("add_ovf_result", bus.out_result, 32'h8000_0000);
`ifdef ALU_EX_OVF_EN
        chk("add_ovf", {31'b0, bus.out_ovf}, 32'd1);
        drive(1'b1, 3'b011, 32'h8000_0000, 32'd1);
        step();
        chk("sub_ovf_result", bus.out_result, 32'h7FFF_FFFF);
        chk("sub_ovf", {31'b0, bus.out_ovf}, 32'd1);
`endif
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        step();

        // flush while in TWO
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b010, 32'd10, 32'd1);
        step();
        drive(1'b1, 3'b010, 32'd20, 32'd2);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        chk("fl_two_ready", {31'b0, bus.in_ready}, 32'd0);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("fl_ready", {31'b0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_no_ghost", {31'b0, bus.out_valid}, 32'd0);
        end

        // asynchronous reset while in TWO
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b111, 32'h0, 32'h8000_0000);
        step();
        drive(1'b1, 3'b100, 32'd7, 32'd1);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        chk("ar_pre_neg", {31'b0, bus.out_neg}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("ar_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("ar_result", bus.out_result, 32'h0);
        chk("ar_neg", {31'b0, bus.out_neg}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("ar_post_valid", {31'b0, bus.out_valid}, 32'd0);
        step();
        chk("ar_post_valid2", {31'b0, bus.out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
